// File: rtl/jk_cmd_gen_if.sv
// Request/command bundle between the raw request lines, enables and the
// JK command stage outputs.
interface jk_cmd_gen_if;
    logic       req_set;
    logic       req_clr;
    logic       req_tgl;
    logic       en;
    logic       conflict_clr;
    logic       j;
    logic       k;
    logic       conflict;
    logic [7:0] cmd_cnt;

    modport master (
        output req_set, req_clr, req_tgl, en, conflict_clr,
        input  j, k, conflict, cmd_cnt
    );

    modport slave (
        input  req_set, req_clr, req_tgl, en, conflict_clr,
        output j, k, conflict, cmd_cnt
    );
endinterface

// File: rtl/jk_cmd_gen.sv
// Synchronises, debounces and edge-detects three raw request lines, then
// arbitrates them into a registered single-cycle {j,k} command.
module jk_cmd_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 5
) (
    input logic        clk,
    input logic        rst_n,
    jk_cmd_gen_if.slave bus
);

    typedef enum logic [1:0] {StLow, StRise, StHigh, StFall} deb_state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    // Channel order: 0 = set, 1 = clear, 2 = toggle.
    logic [2:0] req;
    logic [2:0] evt;

    assign req = {bus.req_tgl, bus.req_clr, bus.req_set};

    for (genvar ch = 0; ch < 3; ch++) begin : g_chan
        logic             sync1_q, sync2_q;
        deb_state_e       state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             evt_q, evt_d;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                state_q <= StLow;
                cnt_q   <= '0;
                evt_q   <= 1'b0;
            end else begin
                sync1_q <= req[ch];
                sync2_q <= sync1_q;
                state_q <= state_d;
                cnt_q   <= cnt_d;
                evt_q   <= evt_d;
            end
        end

        // The sample that leaves a stable state counts as the first of the run.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            evt_d   = 1'b0;
            unique case (state_q)
                StLow: begin
                    if (sync2_q) begin
                        cnt_d   = CntOne;
                        state_d = StRise;
                    end
                end
                StRise: begin
                    if (!sync2_q) begin
                        cnt_d   = '0;
                        state_d = StLow;
                    end else if (cnt_q == CntLast) begin
                        state_d = StHigh;
                        evt_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                StHigh: begin
                    if (!sync2_q) begin
                        cnt_d   = CntOne;
                        state_d = StFall;
                    end
                end
                StFall: begin
                    if (sync2_q) begin
                        cnt_d   = '0;
                        state_d = StHigh;
                    end else if (cnt_q == CntLast) begin
                        state_d = StLow;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                default: state_d = StLow;
            endcase
        end

        assign evt[ch] = evt_q;
    end

    logic       j_q, j_d;
    logic       k_q, k_d;
    logic       conflict_q, conflict_d;
    logic [7:0] cmd_cnt_q, cmd_cnt_d;

    always_comb begin
        j_d = 1'b0;
        k_d = 1'b0;
        if (evt[2]) begin
            j_d = 1'b1;
            k_d = 1'b1;
        end else if (evt[0] && !evt[1]) begin
            j_d = 1'b1;
        end else if (evt[1] && !evt[0]) begin
            k_d = 1'b1;
        end
        if (!bus.en) begin
            j_d = 1'b0;
            k_d = 1'b0;
        end

        // A new conflict outranks a simultaneous clear, and is flagged even when disabled.
        conflict_d = conflict_q;
        if (bus.conflict_clr) conflict_d = 1'b0;
        if (evt[0] && evt[1]) conflict_d = 1'b1;

        cmd_cnt_d = cmd_cnt_q + ((j_d || k_d) ? 8'd1 : 8'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            j_q        <= 1'b0;
            k_q        <= 1'b0;
            conflict_q <= 1'b0;
            cmd_cnt_q  <= 8'd0;
        end else begin
            j_q        <= j_d;
            k_q        <= k_d;
            conflict_q <= conflict_d;
            cmd_cnt_q  <= cmd_cnt_d;
        end
    end

    assign bus.j        = j_q;
    assign bus.k        = k_q;
    assign bus.conflict = conflict_q;
    assign bus.cmd_cnt  = cmd_cnt_q;

endmodule
